// File: rtl/mul_div_result_buffer.sv
// rtl/mul_div_result_buffer.sv - result collection FIFO for the FP multiply/divide core
//
// Captures each valid core result with its exception flags and operation tag.
// The results go into a show-ahead circular FIFO that a valid/ready consumer drains.
// The block also accumulates sticky exception flags and counts results lost to overflow.
//
// Ports:
//   clk, arst                      clock, asynchronous active-high reset
//   in_valid, R, sel               core result, valid strobe, operation tag (0 mul, 1 div)
//   io/dz/of/uf/i_flag             exception flags belonging to R
//   out_valid, out_ready           head handshake towards the consumer
//   out_R, out_flags, out_sel      head entry, flags ordered {io, dz, of, uf, i}
//   count, almost_full             occupancy and stall hint (count >= DEPTH-1)
//   sticky_flags, flags_clr        OR of all captured flags, and its clear
//   drop_cnt                       saturating count of results lost while full
module mul_div_result_buffer #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic                     clk,
    input  logic                     arst,
    input  logic                     in_valid,
    input  logic [W-1:0]             R,
    input  logic                     io_flag,
    input  logic                     dz_flag,
    input  logic                     of_flag,
    input  logic                     uf_flag,
    input  logic                     i_flag,
    input  logic                     sel,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [W-1:0]             out_R,
    output logic [4:0]               out_flags,
    output logic                     out_sel,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     almost_full,
    output logic [4:0]               sticky_flags,
    input  logic                     flags_clr,
    output logic [7:0]               drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] C_DEPTH    = CW'(DEPTH);
    localparam logic [CW-1:0] C_DEPTH_M1 = CW'(DEPTH - 1);

    // Storage is deliberately left out of reset; only the pointers define validity.
    logic [W-1:0]    r_mem_R     [DEPTH];
    logic [4:0]      r_mem_flags [DEPTH];
    logic            r_mem_sel   [DEPTH];

    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic [4:0]      r_sticky;
    logic [7:0]      r_drop_cnt;

    logic            w_pop;
    logic            w_push;
    logic            w_drop;
    logic [4:0]      w_in_flags;

    assign w_in_flags = {io_flag, dz_flag, of_flag, uf_flag, i_flag};
    assign w_pop      = out_valid && out_ready;
    // A pop in the same cycle frees the slot, so a full buffer can still accept.
    assign w_push     = in_valid && ((r_count < C_DEPTH) || w_pop);
    assign w_drop     = in_valid && !w_push;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_R[r_wr_ptr]     <= R;
            r_mem_flags[r_wr_ptr] <= w_in_flags;
            r_mem_sel[r_wr_ptr]   <= sel;
        end
    end

    // The pointers are exactly AW bits wide and DEPTH is a power of two, so they wrap naturally.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // A clear and a capture in the same cycle leave only the incoming flags.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_sticky <= '0;
        end else if (flags_clr) begin
            r_sticky <= in_valid ? w_in_flags : 5'b00000;
        end else if (in_valid) begin
            r_sticky <= r_sticky | w_in_flags;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end

    assign out_valid    = (r_count != '0);
    assign out_R        = r_mem_R[r_rd_ptr];
    assign out_flags    = r_mem_flags[r_rd_ptr];
    assign out_sel      = r_mem_sel[r_rd_ptr];
    assign count        = r_count;
    // Asserts one entry early because the core needs one cycle to react to its enable.
    assign almost_full  = (r_count >= C_DEPTH_M1);
    assign sticky_flags = r_sticky;
    assign drop_cnt     = r_drop_cnt;

endmodule

// File: tb/tb_mul_div_result_buffer.sv
// tb/tb_mul_div_result_buffer.sv - directed self-checking bench for mul_div_result_buffer
module tb_mul_div_result_buffer;

    logic        clk = 1'b0;
    logic        arst;
    logic        in_valid;
    logic [31:0] R;
    logic        io_flag, dz_flag, of_flag, uf_flag, i_flag;
    logic        sel;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_R;
    logic [4:0]  out_flags;
    logic        out_sel;
    logic [2:0]  count;
    logic        almost_full;
    logic [4:0]  sticky_flags;
    logic        flags_clr;
    logic [7:0]  drop_cnt;

    int n_vec = 0;
    int n_err = 0;

    mul_div_result_buffer #(.DEPTH(4), .W(32)) dut (
        .clk          (clk),
        .arst         (arst),
        .in_valid     (in_valid),
        .R            (R),
        .io_flag      (io_flag),
        .dz_flag      (dz_flag),
        .of_flag      (of_flag),
        .uf_flag      (uf_flag),
        .i_flag       (i_flag),
        .sel          (sel),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_R        (out_R),
        .out_flags    (out_flags),
        .out_sel      (out_sel),
        .count        (count),
        .almost_full  (almost_full),
        .sticky_flags (sticky_flags),
        .flags_clr    (flags_clr),
        .drop_cnt     (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are checked there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] data, input logic [4:0] fl, input logic s);
        in_valid = v;
        R        = data;
        {io_flag, dz_flag, of_flag, uf_flag, i_flag} = fl;
        sel      = s;
    endtask

    task automatic push1(input logic [31:0] data, input logic [4:0] fl, input logic s);
        drive(1'b1, data, fl, s);
        tick();
        drive(1'b0, 32'h0, 5'b00000, 1'b0);
    endtask

    logic [31:0] fill_vals [4];
    logic [31:0] exp_q [$];

    initial begin
        fill_vals[0] = 32'h3F800000;
        fill_vals[1] = 32'h40000000;
        fill_vals[2] = 32'h40400000;
        fill_vals[3] = 32'h40800000;

        arst      = 1'b1;
        out_ready = 1'b0;
        flags_clr = 1'b0;
        drive(1'b0, 32'h0, 5'b00000, 1'b0);
        tick();
        tick();
        arst = 1'b0;
        tick();

        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_almost_full", 32'(almost_full), 32'd0);
        chk("rst_sticky", 32'(sticky_flags), 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);

        // Single result
        push1(32'h40490FDB, 5'b00000, 1'b0);
        chk("single_valid", 32'(out_valid), 32'd1);
        chk("single_R", out_R, 32'h40490FDB);
        chk("single_sel", 32'(out_sel), 32'd0);
        chk("single_count", 32'(count), 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("single_pop_count", 32'(count), 32'd0);
        chk("single_pop_valid", 32'(out_valid), 32'd0);

        // Fill and order, with a div tag on the second entry
        for (int k = 0; k < 4; k++) begin
            push1(fill_vals[k], 5'b00000, (k == 1));
            if (k == 1) chk("fill_af_after2", 32'(almost_full), 32'd0);
            if (k == 2) chk("fill_af_after3", 32'(almost_full), 32'd1);
        end
        chk("fill_count", 32'(count), 32'd4);
        chk("fill_drop", 32'(drop_cnt), 32'd0);

        // Overflow while full
        drive(1'b1, 32'hDEADBEEF, 5'b00000, 1'b1);
        for (int k = 0; k < 3; k++) tick();
        drive(1'b0, 32'h0, 5'b00000, 1'b0);
        chk("ovf_drop", 32'(drop_cnt), 32'd3);
        chk("ovf_count", 32'(count), 32'd4);
        chk("ovf_head", out_R, 32'h3F800000);

        // Push with a simultaneous pop at full
        out_ready = 1'b1;
        drive(1'b1, 32'h40A00000, 5'b00000, 1'b0);
        tick();
        drive(1'b0, 32'h0, 5'b00000, 1'b0);
        out_ready = 1'b0;
        chk("full_pp_count", 32'(count), 32'd4);
        chk("full_pp_drop", 32'(drop_cnt), 32'd3);

        // Drain: the remaining three fill values, then the late push
        out_ready = 1'b1;
        for (int k = 1; k < 4; k++) begin
            chk($sformatf("drain_R%0d", k), out_R, fill_vals[k]);
            if (k == 1) chk("drain_sel1", 32'(out_sel), 32'd1);
            tick();
        end
        chk("drain_R4", out_R, 32'h40A00000);
        tick();
        out_ready = 1'b0;
        chk("drain_empty", 32'(out_valid), 32'd0);

        // Sticky flags
        push1(32'h11111111, 5'b00100, 1'b0);
        push1(32'h22222222, 5'b00001, 1'b1);
        chk("sticky_or", 32'(sticky_flags), 32'b00101);
        chk("head_flags", 32'(out_flags), 32'b00100);
        flags_clr = 1'b1;
        push1(32'h33333333, 5'b01000, 1'b0);
        chk("sticky_clr_set", 32'(sticky_flags), 32'b01000);
        tick();
        flags_clr = 1'b0;
        chk("sticky_clr", 32'(sticky_flags), 32'b00000);
        chk("pre_rst_count", 32'(count), 32'd3);

        // Async reset between edges with three entries queued
        #3;
        arst = 1'b1;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_sticky", 32'(sticky_flags), 32'd0);
        chk("arst_drop", 32'(drop_cnt), 32'd0);
        #1;
        arst = 1'b0;
        push1(32'h5A5A5A5A, 5'b10000, 1'b1);
        chk("post_rst_head", out_R, 32'h5A5A5A5A);
        chk("post_rst_count", 32'(count), 32'd1);
        chk("post_rst_sticky", 32'(sticky_flags), 32'b10000);

        // Saturation: fill the buffer, then drop 300 results
        for (int k = 0; k < 3; k++) push1(32'h1000 + 32'(k), 5'b00000, 1'b0);
        drive(1'b1, 32'hBADBAD00, 5'b00000, 1'b0);
        for (int k = 0; k < 300; k++) tick();
        drive(1'b0, 32'h0, 5'b00000, 1'b0);
        chk("sat_drop", 32'(drop_cnt), 32'd255);
        chk("sat_count", 32'(count), 32'd4);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        out_ready = 1'b0;
        chk("sat_drained", 32'(count), 32'd0);

        // Pointer wrap: 37 push/pop pairs while one entry stays resident
        push1(32'hC0000000, 5'b00000, 1'b0);
        exp_q.push_back(32'hC0000000);
        out_ready = 1'b1;
        for (int k = 1; k <= 37; k++) begin
            chk($sformatf("wrap_R%0d", k), out_R, exp_q.pop_front());
            drive(1'b1, 32'hC0000000 + 32'(k), 5'b00000, 1'b0);
            exp_q.push_back(32'hC0000000 + 32'(k));
            tick();
        end
        drive(1'b0, 32'h0, 5'b00000, 1'b0);
        out_ready = 1'b0;
        chk("wrap_count", 32'(count), 32'd1);
        chk("wrap_last", out_R, exp_q.pop_front());
        chk("wrap_drop", 32'(drop_cnt), 32'd255);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
